// File: rtl/result_arbiter.sv
// result_arbiter
// Round-robin owner of the shared 8:1 result-select mux. One requester is
// picked each cycle, its word is captured into a single-entry output stage,
// and a requester may hold the grant across transfers with req_lock.
//
// Handshake: a word moves from requester i when req_ready[i] is high. It
// moves to the consumer on any edge where out_valid and out_ready are both
// high. The stage refills on the same edge it drains, so there is no bubble.
module result_arbiter #(
    parameter int NUM_REQ = 8,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_lock,
    output logic [NUM_REQ-1:0] req_ready,
    output logic [2:0]         mux_select,
    input  logic [DATA_W-1:0]  mux_result,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [2:0]         out_src,
    input  logic               out_ready
);

    // Arbitration state
    logic [2:0]        r_ptr;
    logic              r_locked;
    logic [2:0]        r_lock_id;

    // Output stage
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [2:0]        r_out_src;

    // Combinational arbitration results
    logic [2:0]        w_idx;
    logic [2:0]        w_rr_win;
    logic              w_rr_any;
    logic              w_lock_hit;
    logic [2:0]        w_winner;
    logic              w_any;
    logic              w_can_accept;
    logic              w_accept;

    // Round-robin search starting at r_ptr. The loop runs from the farthest
    // offset down so the nearest requester is assigned last and wins.
    always_comb begin
        w_idx    = r_ptr;
        w_rr_win = r_ptr;
        w_rr_any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = r_ptr + 3'(k);
            if (req_valid[w_idx]) begin
                w_rr_win = w_idx;
                w_rr_any = 1'b1;
            end
        end
    end

    // A held lock overrides round robin only while its owner is still
    // requesting. Otherwise the normal search decides.
    always_comb begin
        w_lock_hit   = r_locked && req_valid[r_lock_id];
        w_winner     = w_lock_hit ? r_lock_id : w_rr_win;
        w_any        = w_lock_hit || w_rr_any;
        w_can_accept = !r_out_valid || out_ready;
        w_accept     = w_can_accept && w_any;
    end

    // Grant is one-hot on the winner. It is forced low during reset.
    always_comb begin
        req_ready = '0;
        if (w_accept && reset_n) begin
            req_ready[w_winner] = 1'b1;
        end
        mux_select = w_any ? w_winner : r_ptr;
    end

    // Pointer and lock bookkeeping on each accepted transfer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr     <= 3'd0;
            r_locked  <= 1'b0;
            r_lock_id <= 3'd0;
        end else if (w_accept) begin
            if (req_lock[w_winner]) begin
                r_locked  <= 1'b1;
                r_lock_id <= w_winner;
            end else begin
                r_locked  <= 1'b0;
                r_ptr     <= w_winner + 3'd1;
            end
        end
    end

    // Output stage: load on accept, drain on out_ready, else hold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= 3'd0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= mux_result;
            r_out_src   <= w_winner;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_result_arbiter.sv
// Bench for result_arbiter: directed scenarios plus a randomized run that is
// checked against a cycle-level behavioural model and an output scoreboard.
module tb_result_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  req_valid;
    logic [7:0]  req_lock;
    logic [7:0]  req_ready;
    logic [2:0]  mux_select;
    logic [31:0] mux_result;
    logic        out_valid;
    logic [31:0] out_data;
    logic [2:0]  out_src;
    logic        out_ready;

    logic [31:0] req_data [8];
    logic [34:0] exp_q [$];

    int checks = 0;
    int errors = 0;

    // Clock
    always #5 clk = ~clk;

    // The requesters' data seen through the shared mux
    assign mux_result = req_data[mux_select];

    result_arbiter #(.NUM_REQ(8), .DATA_W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_lock   (req_lock),
        .req_ready  (req_ready),
        .mux_select (mux_select),
        .mux_result (mux_result),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_ready  (out_ready)
    );

    // Reset with idle inputs; returns 1 time unit after a rising edge
    task automatic apply_reset();
        reset_n   = 1'b0;
        req_valid = 8'h00;
        req_lock  = 8'h00;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) req_data[i] = 32'hA000_0000 + 32'(i);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = 8'hFF;
        req_lock  = 8'h00;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) req_data[i] = 32'hA000_0000 + 32'(i);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 8'h00) begin errors++; $display("FAIL reset_ready got %h want 00", req_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++;
        if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", out_data); end
        checks++;
        if (out_src !== 3'd0) begin errors++; $display("FAIL reset_src got %0d want 0", out_src); end
        reset_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 8'h01) begin errors++; $display("FAIL reset_first_grant got %h want 01", req_ready); end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_src !== 3'd0) begin
            errors++; $display("FAIL reset_first_src got v=%b src=%0d want v=1 src=0", out_valid, out_src);
        end
    endtask

    task automatic test_single();
        apply_reset();
        req_data[3] = 32'hDEADBEEF;
        req_valid   = 8'h08;
        #1;
        checks++;
        if (mux_select !== 3'd3) begin errors++; $display("FAIL single_sel got %0d want 3", mux_select); end
        checks++;
        if (req_ready !== 8'h08) begin errors++; $display("FAIL single_ready got %h want 08", req_ready); end
        @(posedge clk);
        #1;
        req_valid = 8'h00;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_src !== 3'd3) begin
            errors++; $display("FAIL single_out got v=%b d=%h s=%0d want v=1 d=deadbeef s=3", out_valid, out_data, out_src);
        end
        // Pointer moved to 4: requester 5 beats requester 0
        req_valid = 8'h21;
        #1;
        checks++;
        if (mux_select !== 3'd5 || req_ready !== 8'h20) begin
            errors++; $display("FAIL single_ptr got sel=%0d rdy=%h want sel=5 rdy=20", mux_select, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 8'h00;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", out_valid); end
    endtask

    task automatic test_fairness();
        apply_reset();
        req_valid = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_src !== 3'(k % 8) || out_data !== 32'hA000_0000 + 32'(k % 8)) begin
                errors++;
                $display("FAIL fair_seq%0d got v=%b s=%0d d=%h want v=1 s=%0d", k, out_valid, out_src, out_data, k % 8);
            end
        end
        req_valid = 8'h00;
    endtask

    task automatic test_backpressure();
        apply_reset();
        req_valid = 8'hFF;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 8'h00) begin errors++; $display("FAIL bp_ready0 got %h want 00", req_ready); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (req_ready !== 8'h00 || out_valid !== 1'b1 || out_data !== 32'hA000_0000 || out_src !== 3'd0) begin
                errors++;
                $display("FAIL bp_hold%0d got rdy=%h v=%b d=%h s=%0d want rdy=00 v=1 d=a0000000 s=0", k, req_ready, out_valid, out_data, out_src);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 8'h02) begin errors++; $display("FAIL bp_release_ready got %h want 02", req_ready); end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_src !== 3'd1 || out_data !== 32'hA000_0001) begin
            errors++; $display("FAIL bp_next got v=%b s=%0d d=%h want v=1 s=1 d=a0000001", out_valid, out_src, out_data);
        end
        req_valid = 8'h00;
    endtask

    task automatic test_lock_wrap();
        logic [7:0] vseq [5];
        logic [7:0] lseq [5];
        logic [2:0] sseq [5];
        vseq = '{8'h40, 8'h40, 8'h44, 8'h44, 8'h44};
        lseq = '{8'h00, 8'h40, 8'h40, 8'h00, 8'h00};
        sseq = '{3'd6, 3'd6, 3'd6, 3'd6, 3'd2};
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            req_valid = vseq[k];
            req_lock  = lseq[k];
            #1;
            checks++;
            if (mux_select !== sseq[k]) begin
                errors++; $display("FAIL lock_sel%0d got %0d want %0d", k, mux_select, sseq[k]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_src !== sseq[k]) begin
                errors++; $display("FAIL lock_src%0d got v=%b s=%0d want v=1 s=%0d", k, out_valid, out_src, sseq[k]);
            end
        end
        req_valid = 8'h00;
        req_lock  = 8'h00;
    endtask

    task automatic test_mid_reset();
        apply_reset();
        req_valid = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || req_ready !== 8'h00 || out_data !== 32'h0) begin
            errors++; $display("FAIL midrst_clear got v=%b rdy=%h d=%h want v=0 rdy=00 d=0", out_valid, req_ready, out_data);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 8'h01 || mux_select !== 3'd0) begin
            errors++; $display("FAIL midrst_grant got rdy=%h sel=%0d want rdy=01 sel=0", req_ready, mux_select);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_src !== 3'd0) begin
            errors++; $display("FAIL midrst_src got v=%b s=%0d want v=1 s=0", out_valid, out_src);
        end
        req_valid = 8'h00;
    endtask

    // Random traffic against a behavioural model of the arbitration rules
    task automatic test_random();
        bit          pend [8];
        bit          lk   [8];
        int          m_ptr, m_lock_id, m_win;
        bit          m_locked, m_any, m_acc, m_ov;
        logic [31:0] m_od;
        int          m_os;
        logic [7:0]  exp_ready;
        logic [34:0] got;
        apply_reset();
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin pend[i] = 0; lk[i] = 0; end
        m_ptr = 0; m_lock_id = 0; m_locked = 0; m_ov = 0; m_od = '0; m_os = 0;
        for (int c = 0; c < 400; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 8; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i]     = 1;
                    req_data[i] = $urandom;
                    lk[i]       = ($urandom_range(0, 3) == 0);
                end
                req_valid[i] = pend[i];
                req_lock[i]  = pend[i] & lk[i];
            end
            #1;
            // Who should win this cycle
            m_any = 0;
            m_win = m_ptr;
            if (m_locked && pend[m_lock_id]) begin
                m_any = 1;
                m_win = m_lock_id;
            end else begin
                for (int k = 7; k >= 0; k--) begin
                    if (pend[(m_ptr + k) % 8]) begin
                        m_any = 1;
                        m_win = (m_ptr + k) % 8;
                    end
                end
            end
            m_acc     = m_any && (!m_ov || out_ready);
            exp_ready = m_acc ? (8'h01 << m_win) : 8'h00;
            checks++;
            if (req_ready !== exp_ready || mux_select !== 3'(m_win)) begin
                errors++;
                $display("FAIL rand_grant c=%0d got rdy=%h sel=%0d want rdy=%h sel=%0d", c, req_ready, mux_select, exp_ready, m_win);
            end
            // Consumer side scoreboard
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_sb_empty c=%0d got s=%0d d=%h want none", c, out_src, out_data);
                end else begin
                    got = exp_q.pop_front();
                    if ({out_src, out_data} !== got) begin
                        errors++;
                        $display("FAIL rand_sb c=%0d got s=%0d d=%h want s=%0d d=%h", c, out_src, out_data, got[34:32], got[31:0]);
                    end
                end
            end
            if (m_acc) exp_q.push_back({3'(m_win), req_data[m_win]});
            @(posedge clk);
            if (m_acc) begin
                m_ov = 1;
                m_od = req_data[m_win];
                m_os = m_win;
                if (lk[m_win]) begin
                    m_locked  = 1;
                    m_lock_id = m_win;
                end else begin
                    m_locked = 0;
                    m_ptr    = (m_win + 1) % 8;
                end
                pend[m_win] = 0;
                lk[m_win]   = 0;
            end else if (out_ready) begin
                m_ov = 0;
            end
            #1;
            checks++;
            if (out_valid !== m_ov || out_data !== m_od || out_src !== 3'(m_os)) begin
                errors++;
                $display("FAIL rand_out c=%0d got v=%b d=%h s=%0d want v=%b d=%h s=%0d", c, out_valid, out_data, out_src, m_ov, m_od, m_os);
            end
        end
        checks++;
        if (exp_q.size() != (m_ov ? 1 : 0)) begin
            errors++; $display("FAIL rand_sb_left got %0d want %0d", exp_q.size(), m_ov ? 1 : 0);
        end
        req_valid = 8'h00;
        req_lock  = 8'h00;
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 8'h00;
        req_lock  = 8'h00;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) req_data[i] = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_lock_wrap();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
